channel_event_arbiter: RTL and testbench



---
 rtl/channel_arbiter_pkg.sv | 14 +
 rtl/rr_priority_select.sv | 62 ++++++
 rtl/channel_event_arbiter.sv | 101 ++++++++++
 tb/tb_channel_event_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_arbiter_pkg.sv
// Shared types and constants for the channel event arbiter.
package channel_arbiter_pkg;

  // Arbiter phases: IDLE picks a requester, WRITE holds the captured packet until the FIFO takes it.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } arb_state_t;

  localparam int unsigned DEFAULT_NUMCHANNELS = 64;
  localparam int unsigned DEFAULT_WIDTH       = 64;
  localparam int unsigned STALL_CNT_W         = 16;

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority select: rotate the eligible vector so the search starts just above
// last_ptr, find the first set bit, then rotate the offset back to an absolute index.
module rr_priority_select #(
  parameter int unsigned N  = 64,
  parameter int unsigned CW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [CW-1:0] last_ptr,
  output logic [CW-1:0] winner,
  output logic          valid
);

  localparam int unsigned SW = CW + 1;

  logic [SW-1:0] start;
  logic [N-1:0]  rotated;
  logic [SW-1:0] offset;
  logic [SW-1:0] sum;

  // Search start is last_ptr+1, wrapping from N-1 back to 0.
  always_comb begin
    if (last_ptr == CW'(N - 1)) begin
      start = '0;
    end else begin
      start = {1'b0, last_ptr} + SW'(1);
    end
  end

  // Rotate so rotated[0] corresponds to channel 'start'.
  always_comb begin
    rotated = '0;
    for (int i = 0; i < int'(N); i++) begin
      int j;
      j = int'(start) + i;
      if (j >= int'(N)) begin
        j = j - int'(N);
      end
      rotated[i] = eligible[j];
    end
  end

  // Find-first-one from the bottom of the rotated vector.
  always_comb begin
    offset = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = SW'(i);
      end
    end
  end

  // Rotate the offset back to an absolute channel index.
  always_comb begin
    sum = start + offset;
    if (sum >= SW'(N)) begin
      sum = sum - SW'(N);
    end
    winner = sum[CW-1:0];
    valid  = |eligible;
  end

endmodule

// File: rtl/channel_event_arbiter.sv
// Round-robin arbiter sharing the event-FIFO write port among all channel event builders.
// Optional build macro ARB_STALL_COUNT_EN adds a saturating 16-bit stall_count output.
module channel_event_arbiter
  import channel_arbiter_pkg::*;
#(
  parameter int unsigned NUMCHANNELS = DEFAULT_NUMCHANNELS,
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned CHAN_W      = $clog2(NUMCHANNELS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUMCHANNELS-1:0]       channel_req,
  input  logic [NUMCHANNELS*WIDTH-1:0] channel_data,
  input  logic [NUMCHANNELS-1:0]       channel_mask,
  input  logic                         fifo_full,
  output logic                         fifo_wr_en,
  output logic [WIDTH-1:0]             fifo_wr_data,
  output logic [NUMCHANNELS-1:0]       channel_ack,
  output logic [CHAN_W-1:0]            grant_idx,
  output logic                         busy
`ifdef ARB_STALL_COUNT_EN
  ,
  output logic [STALL_CNT_W-1:0]       stall_count
`endif
);

  arb_state_t             state;
  logic [CHAN_W-1:0]      last_ptr;
  logic [WIDTH-1:0]       data_reg;
  logic [NUMCHANNELS-1:0] eligible;
  logic [CHAN_W-1:0]      winner;
  logic                   winner_valid;
  logic [WIDTH-1:0]       winner_data;

  assign eligible = channel_req & ~channel_mask;

  rr_priority_select #(
    .N  (NUMCHANNELS),
    .CW (CHAN_W)
  ) u_select (
    .eligible (eligible),
    .last_ptr (last_ptr),
    .winner   (winner),
    .valid    (winner_valid)
  );

  // Pick out the winning channel's packet for capture at grant.
  always_comb begin
    winner_data = channel_data[32'(winner) * WIDTH +: WIDTH];
  end

  // Grant in IDLE, hold the frozen packet in WRITE until the FIFO has room.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_ptr  <= CHAN_W'(NUMCHANNELS - 1);
      grant_idx <= '0;
      data_reg  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (winner_valid) begin
            grant_idx <= winner;
            data_reg  <= winner_data;
            last_ptr  <= winner;
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (!fifo_full) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STALL_COUNT_EN
  // Count cycles spent blocked by a full FIFO; saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (state == WRITE && fifo_full && stall_count != '1) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end
`endif

  // Write strobe and one-hot ack decode from the registered state and the FIFO full flag.
  always_comb begin
    fifo_wr_en   = (state == WRITE) && !fifo_full;
    fifo_wr_data = data_reg;
    busy         = (state == WRITE);
    channel_ack  = '0;
    if (fifo_wr_en) begin
      channel_ack[grant_idx] = 1'b1;
    end
  end

endmodule

// File: tb/tb_channel_event_arbiter.sv
// Directed bench for channel_event_arbiter with a scoreboard of expected FIFO writes.
module tb_channel_event_arbiter;

  localparam int unsigned NC = 64;
  localparam int unsigned W  = 64;
  localparam int unsigned CW = 6;

  typedef struct packed {
    logic [CW-1:0] idx;
    logic [W-1:0]  data;
  } sb_entry_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [NC-1:0]   channel_req;
  logic [NC*W-1:0] channel_data;
  logic [NC-1:0]   channel_mask;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [W-1:0]    fifo_wr_data;
  logic [NC-1:0]   channel_ack;
  logic [CW-1:0]   grant_idx;
  logic            busy;
`ifdef ARB_STALL_COUNT_EN
  logic [15:0]     stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  sb_entry_t sb[$];

  channel_event_arbiter #(
    .NUMCHANNELS (NC),
    .WIDTH       (W),
    .CHAN_W      (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .channel_req  (channel_req),
    .channel_data (channel_data),
    .channel_mask (channel_mask),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .channel_ack  (channel_ack),
    .grant_idx    (grant_idx),
    .busy         (busy)
`ifdef ARB_STALL_COUNT_EN
    ,
    .stall_count  (stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] data_of(input int k);
    return {32'hC0DE_0000 + 32'(k), 32'h1234_5678 ^ (32'(k) * 32'h0101_0101)};
  endfunction

  function automatic logic [NC-1:0] onehot(input logic [CW-1:0] k);
    logic [NC-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic push(input int k, input logic [W-1:0] d);
    sb_entry_t e;
    e.idx  = CW'(k);
    e.data = d;
    sb.push_back(e);
  endtask

  // Drive just after the active edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every write must match the next expected packet, channel and ack.
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      wr_count++;
      if (sb.size() == 0) begin
        check("unexpected_write", fifo_wr_data, '0);
        check("unexpected_write_idx", W'(grant_idx), W'(NC));
      end else begin
        sb_entry_t e;
        e = sb.pop_front();
        check("wr_data", fifo_wr_data, e.data);
        check("wr_ack", channel_ack, onehot(e.idx));
        check("wr_grant_idx", W'(grant_idx), W'(e.idx));
      end
    end else begin
      check("ack_idle", channel_ack, '0);
    end
  end

  initial begin
    int wr_base;
    reset        = 1'b1;
    channel_req  = '0;
    channel_mask = '0;
    fifo_full    = 1'b0;
    for (int k = 0; k < int'(NC); k++) channel_data[k*W +: W] = data_of(k);

    // Reset state.
    tick(3);
    @(negedge clk);
    check("rst_wr_en", W'(fifo_wr_en), 0);
    check("rst_busy", W'(busy), 0);
    check("rst_grant_idx", W'(grant_idx), 0);
    check("rst_wr_data", fifo_wr_data, 0);
`ifdef ARB_STALL_COUNT_EN
    check("rst_stall_count", W'(stall_count), 0);
`endif
    tick(1);
    reset = 1'b0;

    // Single request on channel 5: write and ack one cycle after it is seen.
    channel_data[5*W +: W] = 64'hDEAD_BEEF_0000_0005;
    channel_req = onehot(CW'(5));
    push(5, 64'hDEAD_BEEF_0000_0005);
    tick(1);
    channel_req = '0;
    @(negedge clk);
    check("single_wr_en", W'(fifo_wr_en), 1);
    check("single_busy", W'(busy), 1);
    check("single_grant", W'(grant_idx), 5);
    tick(1);
    @(negedge clk);
    check("single_idle_busy", W'(busy), 0);
    check("single_idle_wr_en", W'(fifo_wr_en), 0);
    channel_data[5*W +: W] = data_of(5);

    // Round-robin from reset: 0..63 then 0,1, exactly 64 writes in 128 cycles.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    for (int k = 0; k < int'(NC); k++) push(k, data_of(k));
    push(0, data_of(0));
    push(1, data_of(1));
    wr_base = wr_count;
    channel_req = '1;
    tick(128);
    check("rr_writes_128", W'(wr_count - wr_base), 64);
    tick(4);
    channel_req = '0;
    check("rr_sb_drained", W'(sb.size()), 0);

    // Backpressure on channel 10 for 7 cycles.
    channel_req = onehot(CW'(10));
    fifo_full = 1'b1;
    push(10, data_of(10));
    tick(1);
    channel_req = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("stall_wr_en", W'(fifo_wr_en), 0);
      check("stall_busy", W'(busy), 1);
      tick(1);
    end
    fifo_full = 1'b0;
    @(negedge clk);
    check("stall_release_wr_en", W'(fifo_wr_en), 1);
    check("stall_release_grant", W'(grant_idx), 10);
`ifdef ARB_STALL_COUNT_EN
    check("stall_count_7", W'(stall_count), 7);
`endif
    tick(1);

    // Mask: channel 0 masked so only 1 wins; unmasked 0 wins next.
    channel_req  = 64'h3;
    channel_mask = 64'h1;
    push(1, data_of(1));
    tick(1);
    @(negedge clk);
    check("mask_grant1", W'(grant_idx), 1);
    tick(1);
    channel_mask = '0;
    push(0, data_of(0));
    tick(1);
    channel_req = '0;
    @(negedge clk);
    check("unmask_grant0", W'(grant_idx), 0);
    tick(1);

    // Data freeze: packet captured at grant survives data change and req drop.
    channel_req = onehot(CW'(3));
    push(3, data_of(3));
    tick(1);
    channel_data[3*W +: W] = ~data_of(3);
    channel_req = '0;
    @(negedge clk);
    check("freeze_data", fifo_wr_data, data_of(3));
    tick(1);
    channel_data[3*W +: W] = data_of(3);

    // Reset mid-stall: channel 20 packet dropped without ack, then channel 0 wins first.
    channel_req = onehot(CW'(20));
    fifo_full = 1'b1;
    tick(2);
    channel_req = '0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    fifo_full = 1'b0;
    channel_req = '1;
    push(0, data_of(0));
    @(negedge clk);
    check("midrst_busy", W'(busy), 0);
    check("midrst_wr_en", W'(fifo_wr_en), 0);
    check("midrst_grant_idx", W'(grant_idx), 0);
    check("midrst_wr_data", fifo_wr_data, 0);
    check("midrst_ack", channel_ack, 0);
`ifdef ARB_STALL_COUNT_EN
    check("midrst_stall_count", W'(stall_count), 0);
`endif
    tick(1);
    channel_req = '0;
    @(negedge clk);
    check("midrst_first_grant", W'(grant_idx), 0);
    check("midrst_first_wr_en", W'(fifo_wr_en), 1);
    tick(3);
    check("final_sb_empty", W'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
